lrf_pixel_packer: RTL and testbench
===================================

Name: lrf_pixel_packer

Overview:
- Upstream feeder for the LRF fusion stage.
- Accepts a 1-pixel-per-beat 8-bit AXI-Stream from the capture/DMA side and packs PIXELS_PER_BEAT pixels into each DATA_WIDTH beat.
- Regenerates frame-aligned m_tlast every BEATS_PER_IMAGE beats, matching exactly the beat/tlast framing the LRF slave port consumes.
- Checks input framing against the configured image size and reports mismatches through sticky error flags.

Parameters:
PIXELS_PER_BEAT, 8, pixels packed per output beat.
IMAGE_DIM, 16, image is IMAGE_DIM x IMAGE_DIM 8-bit pixels.
DATA_WIDTH, 8*PIXELS_PER_BEAT, output data width (derived, do not override).
BEATS_PER_IMAGE, IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, output beats per frame (derived).

Ports:
clk  in  1  clock; all logic on rising edge.
aresetn  in  1  reset, asynchronous assert, active-low.
s_tdata  in  8  input pixel.
s_tvalid  in  1  input pixel valid.
s_tready  out  1  input pixel accepted when s_tvalid && s_tready.
s_tlast  in  1  marks last pixel of input frame.
m_tdata  out  DATA_WIDTH  packed beat; pixel 0 of beat in the most-significant byte.
m_tvalid  out  1  output beat valid.
m_tready  in  1  downstream ready.
m_tlast  out  1  last beat of frame.
err_early  out  1  sticky: s_tlast seen before the frame was complete.
err_late  out  1  sticky: frame completed without s_tlast on its final pixel.
frame_count  out  16  completed output frames (see Optional Feature).

Behaviour:
- Reset state (aresetn low, asynchronous):
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - err_early=0, err_late=0, frame_count=0.
  - Pixel index and beat counter = 0.
  - s_tready forced 0 while aresetn is low.
- Output register handshake:
  - Single output register; holds beat and m_tlast stable while m_tvalid && !m_tready.
  - s_tready = aresetn && (!m_tvalid || m_tready). Combinational path from m_tready is permitted.
  - Full throughput with m_tready=1: one pixel per cycle, one beat every PIXELS_PER_BEAT cycles.
- Assembly:
  - Accepted pixel k (0..P-1) is written into assembly byte k.
  - On acceptance of pixel P-1, the completed beat loads into the output register on that same edge.
  - m_tvalid is high the following cycle (latency 1 clk from the last pixel of the beat).
  - The assembly register is cleared after each load.
- Beat counter (0..BEATS_PER_IMAGE-1):
  - Increments when a beat is loaded into the output register.
  - Wraps to 0 on the loaded beat whose index is BEATS_PER_IMAGE-1; m_tlast=1 on that beat only.
- Normal frame: s_tlast on pixel IMAGE_DIM^2-1 coincides with the internal boundary; no error.
- Early s_tlast (internal frame not yet complete):
  - Remaining bytes of the current beat are zero-padded and the beat is loaded immediately with m_tlast=1.
  - Beat counter and pixel index reset to 0; err_early set.
  - The partial frame still counts as a frame.
- Late (internal boundary reached and s_tlast=0 on that pixel):
  - m_tlast=1 is still emitted on the boundary beat and err_late is set.
  - Following pixels start a new frame.
- Error flags are sticky until reset.
- Output register loads only on a pixel handshake, so a loaded beat never overwrites an undrained beat.
- Reset asserted mid-frame:
  - Partial assembly and any pending output beat are discarded.
  - After release, the next pixel is treated as pixel 0 of beat 0.

Optional Feature:
FRAME_CNT_EN
- Defined: frame_count increments by 1, wrapping at 16 bits, on each m_tlast beat handshake (m_tvalid && m_tready && m_tlast).
- Undefined: frame_count is tied to 0 and the counter logic is not built.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, m_tready=1, pixels 0..255 with s_tlast on 255:
  - 32 beats out; beat0 = 0x0001020304050607, beat31 = 0xF8F9FAFBFCFDFEFF with m_tlast=1.
  - m_tlast=0 on all other beats; no errors.
- Same stream with m_tready toggling randomly (seeded):
  - Identical beat sequence; m_tdata/m_tlast stable while stalled.
  - No lost or duplicated pixels; s_tready=0 exactly when m_tvalid && !m_tready.
- s_tlast on pixel 11 (value 0x0B):
  - Beat1 = 0x08090A0B00000000 with m_tlast=1; err_early=1.
  - Next pixel 0x40 appears in the MSB byte of the next beat.
- 256 pixels with no s_tlast, then 256 more:
  - m_tlast on output beats 31 and 63; err_late=1 after beat 31; err_early=0.
- aresetn pulsed low after pixel 100:
  - Outputs return to reset values immediately.
  - The next frame's pixel 0 lands in beat0 MSB; frame_count=0.
- FRAME_CNT_EN defined, 3 back-to-back frames:
  - frame_count=3.
  - Same run with macro undefined: frame_count stays 0.

Source files
------------

// File: rtl/lrf_pixel_packer.sv
// Packs a 1-pixel-per-beat 8-bit stream into PIXELS_PER_BEAT-pixel beats with frame-aligned tlast.
// Optional macro FRAME_CNT_EN builds the completed-frame counter; otherwise frame_count is tied to 0.
module lrf_pixel_packer #(
  parameter  int PIXELS_PER_BEAT = 8,
  parameter  int IMAGE_DIM       = 16,
  localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  localparam int BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  err_early,
  output logic                  err_late,
  output logic [15:0]           frame_count
);

  localparam int PIX_W  = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
  localparam int BEAT_W = (BEATS_PER_IMAGE > 1) ? $clog2(BEATS_PER_IMAGE) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS_PER_BEAT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_IMAGE - 1);

  logic [DATA_WIDTH-1:0] r_asm;
  logic [PIX_W-1:0]      r_pix_idx;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_err_early;
  logic                  r_err_late;

  logic                  w_acc;
  logic                  w_last_pix;
  logic                  w_boundary;
  logic [DATA_WIDTH-1:0] w_beat;

  assign s_tready   = aresetn && (!r_m_valid || m_tready);
  assign w_acc      = s_tvalid && s_tready;
  assign w_last_pix = (r_pix_idx == LAST_PIX);
  assign w_boundary = w_last_pix && (r_beat_cnt == LAST_BEAT);

  // Pixel 0 of a beat lives in the most-significant byte.
  always_comb begin
    w_beat = r_asm;
    for (int unsigned k = 0; k < PIXELS_PER_BEAT; k++) begin
      if (r_pix_idx == PIX_W'(k))
        w_beat[(PIXELS_PER_BEAT - 1 - k) * 8 +: 8] = s_tdata;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_asm       <= '0;
      r_pix_idx   <= '0;
      r_beat_cnt  <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      if (r_m_valid && m_tready)
        r_m_valid <= 1'b0;
      if (w_acc) begin
        if (s_tlast && !w_boundary) begin
          // Early end: unfilled bytes of r_asm are already zero, so the beat is zero-padded.
          r_m_data    <= w_beat;
          r_m_valid   <= 1'b1;
          r_m_last    <= 1'b1;
          r_asm       <= '0;
          r_pix_idx   <= '0;
          r_beat_cnt  <= '0;
          r_err_early <= 1'b1;
        end else if (w_last_pix) begin
          r_m_data   <= w_beat;
          r_m_valid  <= 1'b1;
          r_m_last   <= w_boundary;
          r_asm      <= '0;
          r_pix_idx  <= '0;
          r_beat_cnt <= w_boundary ? '0 : r_beat_cnt + 1'b1;
          if (w_boundary && !s_tlast)
            r_err_late <= 1'b1;
        end else begin
          r_asm     <= w_beat;
          r_pix_idx <= r_pix_idx + 1'b1;
        end
      end
    end
  end

  assign m_tdata   = r_m_data;
  assign m_tvalid  = r_m_valid;
  assign m_tlast   = r_m_last;
  assign err_early = r_err_early;
  assign err_late  = r_err_late;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_frame_cnt <= '0;
    else if (r_m_valid && m_tready && r_m_last)
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_count = r_frame_cnt;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_lrf_pixel_packer.sv
// Directed bench for lrf_pixel_packer: beat tables, stall stability, early/late framing, reset, frame count.
module tb_lrf_pixel_packer;
  localparam int P   = 8;
  localparam int DIM = 16;
  localparam int DW  = 64;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          err_early;
  logic          err_late;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  lrf_pixel_packer #(.PIXELS_PER_BEAT(P), .IMAGE_DIM(DIM)) u_dut (
    .clk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .err_early(err_early), .err_late(err_late), .frame_count(frame_count)
  );

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_vec_t;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  bit            rand_ready = 1'b0;
  bit            held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] seq_beat(input int unsigned b);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned j = 0; j < P; j++) v[(P - 1 - j) * 8 +: 8] = 8'(b * P + j);
    return v;
  endfunction

  // Inputs change on the falling edge; handshakes happen on the following rising edge.
  task automatic cycle(input bit pv, input logic [7:0] pd, input bit pl, output bit acc);
    @(negedge clk);
    m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    s_tvalid = pv;
    s_tdata  = pd;
    s_tlast  = pl;
    #1;
    if (held_v) begin
      chk("stall_valid", 64'(m_tvalid), 64'(1));
      chk("stall_data", m_tdata, held_d);
      chk("stall_last", 64'(m_tlast), 64'(held_l));
    end
    chk("s_tready", 64'(s_tready), 64'(!(m_tvalid && !m_tready)));
    if (m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_last.push_back(m_tlast);
    end
    held_v = m_tvalid && !m_tready;
    held_d = m_tdata;
    held_l = m_tlast;
    acc    = pv && s_tready;
    @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    bit a;
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, l, a);
      n++;
    end while (!a && n < 100);
    if (!a) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain(input int unsigned want);
    bit a;
    int n;
    n = 0;
    while (q_data.size() < want && n < 300) begin
      cycle(1'b0, 8'h00, 1'b0, a);
      n++;
    end
    cycle(1'b0, 8'h00, 1'b0, a);
    chk("beat_count", 64'(q_data.size()), 64'(want));
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    held_v   = 1'b0;
    q_data.delete();
    q_last.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic send_frame(input int unsigned n, input bit tlast_at_end);
    for (int unsigned i = 0; i < n; i++)
      send(8'(i), tlast_at_end && (i == n - 1));
  endtask

  initial begin
    beat_vec_t t1[4];
    beat_vec_t t3[3];
    logic [DW-1:0] pre_rst;

    t1[0] = '{idx: 0,  data: 64'h0001020304050607, last: 1'b0};
    t1[1] = '{idx: 1,  data: 64'h08090A0B0C0D0E0F, last: 1'b0};
    t1[2] = '{idx: 16, data: 64'h8081828384858687, last: 1'b0};
    t1[3] = '{idx: 31, data: 64'hF8F9FAFBFCFDFEFF, last: 1'b1};
    t3[0] = '{idx: 0,  data: 64'h0001020304050607, last: 1'b0};
    t3[1] = '{idx: 1,  data: 64'h08090A0B00000000, last: 1'b1};
    t3[2] = '{idx: 2,  data: 64'h4041424344454647, last: 1'b0};

    void'($urandom(32'h5EED1234));
    aresetn  = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    #2;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", m_tdata, 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_errors", 64'({err_early, err_late}), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    do_reset();

    // Full frame at full throughput.
    send_frame(256, 1'b1);
    drain(32);
    for (int i = 0; i < 4; i++) begin
      if (t1[i].idx < q_data.size()) begin
        chk($sformatf("t1_data_b%0d", t1[i].idx), q_data[t1[i].idx], t1[i].data);
        chk($sformatf("t1_last_b%0d", t1[i].idx), 64'(q_last[t1[i].idx]), 64'(t1[i].last));
      end
    end
    for (int unsigned b = 0; b < q_data.size(); b++)
      chk($sformatf("t1_last_all_b%0d", b), 64'(q_last[b]), 64'(b == 31));
    chk("t1_errors", 64'({err_early, err_late}), 64'(0));

    // Same frame with random backpressure.
    do_reset();
    rand_ready = 1'b1;
    send_frame(256, 1'b1);
    drain(32);
    rand_ready = 1'b0;
    for (int unsigned b = 0; b < q_data.size(); b++) begin
      chk($sformatf("t2_data_b%0d", b), q_data[b], seq_beat(b));
      chk($sformatf("t2_last_b%0d", b), 64'(q_last[b]), 64'(b == 31));
    end
    chk("t2_errors", 64'({err_early, err_late}), 64'(0));

    // Early tlast on pixel 11, then a new frame starting with 0x40.
    do_reset();
    send_frame(12, 1'b1);
    for (int unsigned i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b0);
    drain(3);
    for (int i = 0; i < 3; i++) begin
      if (t3[i].idx < q_data.size()) begin
        chk($sformatf("t3_data_b%0d", t3[i].idx), q_data[t3[i].idx], t3[i].data);
        chk($sformatf("t3_last_b%0d", t3[i].idx), 64'(q_last[t3[i].idx]), 64'(t3[i].last));
      end
    end
    chk("t3_err_early", 64'(err_early), 64'(1));
    chk("t3_err_late", 64'(err_late), 64'(0));

    // Missing tlast: boundaries still marked, err_late set only once the boundary passes.
    do_reset();
    send_frame(255, 1'b0);
    chk("t4_err_late_before", 64'(err_late), 64'(0));
    send(8'hFF, 1'b0);
    send_frame(256, 1'b0);
    drain(64);
    for (int unsigned b = 0; b < q_data.size(); b++) begin
      chk($sformatf("t4_data_b%0d", b), q_data[b], seq_beat(b % 32));
      chk($sformatf("t4_last_b%0d", b), 64'(q_last[b]), 64'(b == 31 || b == 63));
    end
    chk("t4_err_late", 64'(err_late), 64'(1));
    chk("t4_err_early", 64'(err_early), 64'(0));

    // Reset mid-frame after pixel 100.
    do_reset();
    send_frame(101, 1'b0);
    drain(12);
    pre_rst = m_tdata;
    chk("t5_held_data", pre_rst, seq_beat(11));
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_m_tdata", m_tdata, 64'(0));
    chk("t5_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("t5_rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("t5_rst_s_tready", 64'(s_tready), 64'(0));
    @(negedge clk);
    aresetn = 1'b1;
    held_v  = 1'b0;
    q_data.delete();
    q_last.delete();
    for (int unsigned i = 0; i < 8; i++) send(8'(8'hA0 + i), 1'b0);
    drain(1);
    if (q_data.size() > 0) begin
      chk("t5_first_beat", q_data[0], 64'hA0A1A2A3A4A5A6A7);
      chk("t5_first_last", 64'(q_last[0]), 64'(0));
    end
    chk("t5_frame_count", 64'(frame_count), 64'(0));

    // Three back-to-back frames.
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(256, 1'b1);
    drain(96);
    @(negedge clk);
`ifdef FRAME_CNT_EN
    chk("t6_frame_count", 64'(frame_count), 64'(3));
`else
    chk("t6_frame_count", 64'(frame_count), 64'(0));
`endif
    for (int unsigned b = 0; b < q_data.size(); b++)
      chk($sformatf("t6_last_b%0d", b), 64'(q_last[b]), 64'((b % 32) == 31));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
